// File: rtl/ram_responder_if.sv
// Request/acknowledge bus between a memory initiator and ram_responder.
// The initiator holds ram_aval until ram_ack; ram_busy reports a non-idle responder.
interface ram_responder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();
    logic              ram_aval;
    logic              ram_rnw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_busy;

    modport master (
        output ram_aval, ram_rnw, ram_addr, ram_wdata,
        input  ram_ack, ram_rdata, ram_busy
    );

    modport slave (
        input  ram_aval, ram_rnw, ram_addr, ram_wdata,
        output ram_ack, ram_rdata, ram_busy
    );
endinterface

// File: rtl/ram_responder.sv
// Fixed-latency single-port RAM responder: captures a request, waits LATENCY cycles,
// performs the access with a one-cycle ack, then waits for ram_aval to drop.
module ram_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 4
) (
    input  logic            clk,
    input  logic            reset,
    ram_responder_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StWait, StRelease} state_e;

    localparam logic [7:0] LatInit = 8'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_we;

    // Storage is deliberately not reset.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.ram_aval) begin
                    rnw_d   = bus.ram_rnw;
                    addr_d  = bus.ram_addr;
                    wdata_d = bus.ram_wdata;
                    cnt_d   = LatInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = StRelease;
                    if (rnw_q) rdata_d = mem[addr_q];
                    else       mem_we  = 1'b1;
                end
            end
            // A held request must drop before another can be accepted.
            StRelease: begin
                if (!bus.ram_aval) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // mem_we derives from state_q, so a reset during WAIT suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    assign bus.ram_ack   = ack_q;
    assign bus.ram_rdata = rdata_q;
    assign bus.ram_busy  = (state_q != StIdle);
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed scenarios plus random traffic on a LATENCY=4 and a
// LATENCY=1 instance, checked against an array-based memory model.
module tb_ram_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        aval;
    logic        rnw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        busy;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [2][256];
    logic [31:0] exp_rdata [2];

    always #5 clk = ~clk;

    ram_responder_if #(.ADDR_W(8), .DATA_W(32)) bus4 ();
    ram_responder_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

    assign bus4.ram_aval  = aval && !sel;
    assign bus4.ram_rnw   = rnw;
    assign bus4.ram_addr  = addr;
    assign bus4.ram_wdata = wdata;
    assign bus1.ram_aval  = aval && sel;
    assign bus1.ram_rnw   = rnw;
    assign bus1.ram_addr  = addr;
    assign bus1.ram_wdata = wdata;

    assign ack   = sel ? bus1.ram_ack   : bus4.ram_ack;
    assign busy  = sel ? bus1.ram_busy  : bus4.ram_busy;
    assign rdata = sel ? bus1.ram_rdata : bus4.ram_rdata;

    ram_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    ram_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)",
                                  tag, got, exp, $time, sel);
        else n_pass++;
    endtask

    // One full transaction from an idle responder; drop_at in 1..lat aborts before that edge.
    task automatic txn(input logic r, input logic [7:0] a, input logic [31:0] d,
                       input int drop_at, input int hold);
        int lat;
        bit dropped;
        lat     = sel ? 1 : 4;
        dropped = 1'b0;
        aval = 1'b1; rnw = r; addr = a; wdata = d;
        @(posedge clk); #1;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_noack", 32'(ack), 32'd0);
        for (int k = 1; k <= lat; k++) begin
            if (k == drop_at) begin
                aval    = 1'b0;
                dropped = 1'b1;
            end
            // Inputs after acceptance must not matter.
            rnw = 1'($urandom); addr = 8'($urandom); wdata = $urandom;
            @(posedge clk); #1;
            if (k < lat) begin
                check("wait_noack", 32'(ack), 32'd0);
                check("wait_busy", 32'(busy), 32'd1);
            end
        end
        check("ack_at_latency", 32'(ack), 32'd1);
        check("ack_busy", 32'(busy), 32'd1);
        if (r) exp_rdata[sel] = ref_mem[sel][a];
        else   ref_mem[sel][a] = d;
        check("ack_rdata", rdata, exp_rdata[sel]);
        if (!dropped) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check("hold_noack", 32'(ack), 32'd0);
                check("hold_busy", 32'(busy), 32'd1);
                check("hold_rdata", rdata, exp_rdata[sel]);
            end
        end
        aval = 1'b0;
        @(posedge clk); #1;
        check("release_idle", 32'(busy), 32'd0);
        check("release_noack", 32'(ack), 32'd0);
        check("release_rdata", rdata, exp_rdata[sel]);
    endtask

    initial begin
        reset = 1'b0; sel = 1'b0; aval = 1'b0; rnw = 1'b0; addr = '0; wdata = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); #1;
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_ack", 32'(ack), 32'd0);
            check("reset_rdata", rdata, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk); reset = 1'b1;

        // Write then read back.
        txn(1'b0, 8'h12, 32'hDEAD_BEEF, 0, 0);
        txn(1'b1, 8'h12, 32'h0, 0, 0);
        // Request held long after ack.
        txn(1'b0, 8'h40, 32'h0BAD_F00D, 0, 10);
        // Eviction-style write then read with a one-cycle gap.
        txn(1'b0, 8'h05, 32'h1111_1111, 0, 0);
        txn(1'b1, 8'h05, 32'h0, 0, 0);
        // Abort after one cycle still completes the write.
        txn(1'b0, 8'h20, 32'hA5A5_A5A5, 1, 0);
        txn(1'b1, 8'h20, 32'h0, 0, 0);

        // Reset during WAIT of an overwrite must leave the old data.
        txn(1'b0, 8'h30, 32'h7, 0, 0);
        txn(1'b1, 8'h30, 32'h0, 0, 0);
        aval = 1'b1; rnw = 1'b0; addr = 8'h30; wdata = 32'h1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("midreset_ack", 32'(ack), 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        rnw = 1'b1; addr = 8'h30;
        @(negedge clk); reset = 1'b1;
        // aval is already high: accepted at the first edge out of reset.
        txn(1'b1, 8'h30, 32'h0, 0, 0);

        // LATENCY=1 instance: back-to-back with one-cycle gaps.
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            txn(1'(i % 2), 8'h50 + 8'(i / 2), 32'hC0DE_0000 + 32'(i), 0, 0);
        end

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int a = 0; a < 16; a++) txn(1'b0, 8'(a), $urandom, 0, 0);
            for (int n = 0; n < 40; n++) begin
                txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                    int'($urandom_range(0, s ? 2 : 5)), int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
